// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle CPU: branch conditions, PC sources and
// the fetch FSM states.
package mc_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_EQ   = 3'b001;
  localparam logic [2:0] BR_NE   = 3'b010;
  localparam logic [2:0] BR_LT   = 3'b011;
  localparam logic [2:0] BR_GT   = 3'b100;
  localparam logic [2:0] BR_EQZ  = 3'b101;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUREG = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_BRANCH = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StFetch = 2'b01,
    StDone  = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and memory.
interface pc_fetch_unit_if #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned ADDR_W    = 32
);
  logic                 imem_req;
  logic [ADDR_W-1:0]    imem_addr;
  logic                 imem_ack;
  logic [DATA_SIZE-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/branch_eval.sv
// Combinational branch-condition evaluator; shared with future pipelined cores.
module branch_eval
  import mc_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 32
) (
  input  logic [DATA_SIZE-1:0] reg_a,
  input  logic [DATA_SIZE-1:0] reg_b,
  input  logic [2:0]           branch_type,
  output logic                 branch_taken
);

  always_comb begin
    branch_taken = 1'b0;
    case (branch_type)
      BR_EQ:   branch_taken = (reg_a == reg_b);
      BR_NE:   branch_taken = (reg_a != reg_b);
      BR_LT:   branch_taken = ($signed(reg_a) < $signed(reg_b));
      BR_GT:   branch_taken = ($signed(reg_a) > $signed(reg_b));
      BR_EQZ:  branch_taken = (reg_a == '0);
      default: branch_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, instruction register and variable-latency fetch FSM with
// timeout, plus next-PC selection for jumps, branches and ALU targets.
module pc_fetch_unit
  import mc_pkg::*;
#(
  parameter int unsigned       DATA_SIZE = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_start,
  output logic                 fetch_done,
  output logic                 fetch_err,
  output logic                 busy,
  pc_fetch_unit_if.master      imem,
  output logic [DATA_SIZE-1:0] ir,
  output logic [ADDR_W-1:0]    pc,
  input  logic                 pc_write,
  input  logic [1:0]           pc_source,
  input  logic [DATA_SIZE-1:0] alu_wire,
  input  logic [DATA_SIZE-1:0] alu_reg,
  input  logic [2:0]           branch_type,
  input  logic [DATA_SIZE-1:0] reg_a,
  input  logic [DATA_SIZE-1:0] reg_b,
  output logic                 branch_taken
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  fetch_state_e         state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [DATA_SIZE-1:0] ir_q, ir_d;
  logic                 err_q, err_d;
  logic [ADDR_W-1:0]    jmp_off, br_off, pc_next;
  logic [1:0]           eff_src;

  branch_eval #(
    .DATA_SIZE(DATA_SIZE)
  ) u_branch_eval (
    .reg_a       (reg_a),
    .reg_b       (reg_b),
    .branch_type (branch_type),
    .branch_taken(branch_taken)
  );

  // Offsets come from the registered ir, never from the incoming memory word.
  assign jmp_off = ADDR_W'($signed(ir_q[25:0]));
  assign br_off  = ADDR_W'($signed(ir_q[15:0]));
  assign eff_src = branch_taken ? PCS_BRANCH : pc_source;

  always_comb begin
    pc_next = pc_q;
    unique case (eff_src)
      PCS_ALU:    pc_next = alu_wire[ADDR_W-1:0];
      PCS_ALUREG: pc_next = alu_reg[ADDR_W-1:0];
      PCS_JUMP:   pc_next = pc_q + jmp_off;
      PCS_BRANCH: pc_next = pc_q + br_off;
      default:    pc_next = pc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    err_d   = err_q;
    pc_d    = pc_q;
    unique case (state_q)
      StIdle: begin
        if (fetch_start) begin
          state_d = StFetch;
          cnt_d   = '0;
          addr_d  = pc_q;
        end
      end
      StFetch: begin
        if (imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          state_d = StDone;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Dropping writes mid-fetch keeps the in-flight address coherent with pc.
    if (pc_write && state_q != StFetch) pc_d = pc_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= RESET_PC;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  assign imem.imem_req  = (state_q == StFetch);
  assign imem.imem_addr = addr_q;
  assign fetch_done     = (state_q == StDone);
  assign busy           = (state_q != StIdle);
  assign fetch_err      = err_q;
  assign ir             = ir_q;
  assign pc             = pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a 32-bit-address instance plus an 8-bit
// one sharing all stimulus, used for the address wrap case.
module tb_pc_fetch_unit;
  import mc_pkg::*;

  localparam int unsigned Timeout = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, fetch_start, pc_write, mem_ack;
  logic [31:0] mem_rdata, alu_wire, alu_reg, reg_a, reg_b;
  logic [1:0]  pc_source;
  logic [2:0]  branch_type;

  logic        fetch_done, fetch_err, busy, branch_taken;
  logic [31:0] ir, pc;
  logic        fetch_done8, fetch_err8, busy8, branch_taken8;
  logic [31:0] ir8;
  logic [7:0]  pc8;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit_if #(.DATA_SIZE(32), .ADDR_W(32)) bus ();
  pc_fetch_unit_if #(.DATA_SIZE(32), .ADDR_W(8))  bus8 ();

  assign bus.imem_ack    = mem_ack;
  assign bus.imem_rdata  = mem_rdata;
  assign bus8.imem_ack   = mem_ack;
  assign bus8.imem_rdata = mem_rdata;

  pc_fetch_unit #(.DATA_SIZE(32), .ADDR_W(32), .RESET_PC(32'h0), .TIMEOUT(Timeout)) u_dut (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .fetch_done(fetch_done),
    .fetch_err(fetch_err), .busy(busy), .imem(bus), .ir(ir), .pc(pc), .pc_write(pc_write),
    .pc_source(pc_source), .alu_wire(alu_wire), .alu_reg(alu_reg),
    .branch_type(branch_type), .reg_a(reg_a), .reg_b(reg_b), .branch_taken(branch_taken)
  );

  pc_fetch_unit #(.DATA_SIZE(32), .ADDR_W(8), .RESET_PC(8'h0), .TIMEOUT(Timeout)) u_dut8 (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .fetch_done(fetch_done8),
    .fetch_err(fetch_err8), .busy(busy8), .imem(bus8), .ir(ir8), .pc(pc8), .pc_write(pc_write),
    .pc_source(pc_source), .alu_wire(alu_wire), .alu_reg(alu_reg),
    .branch_type(branch_type), .reg_a(reg_a), .reg_b(reg_b), .branch_taken(branch_taken8)
  );

  typedef struct {
    logic [2:0]  bt;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp;
  } br_vec_t;

  typedef struct {
    logic [31:0] ir_word;
    logic [31:0] start_pc;
    logic [1:0]  src;
    logic [31:0] alu_w;
    logic [31:0] alu_r;
    logic [2:0]  bt;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp_taken;
    logic [31:0] exp_pc;
  } pc_vec_t;

  br_vec_t bv[14];
  pc_vec_t pv[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts a fetch and plays memory: ack arrives on request cycle delay+1.
  // Returns at the DONE-cycle negedge, or at the idle negedge after a timeout.
  task automatic run_fetch(input logic [31:0] word, input int delay, output int req_cycles,
                           output int lat, output bit done_seen, output bit addr_stable,
                           output logic [31:0] first_addr);
    req_cycles  = 0;
    lat         = 0;
    done_seen   = 1'b0;
    addr_stable = 1'b1;
    first_addr  = 32'hx;
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (fetch_done) begin
        done_seen = 1'b1;
        lat       = c + 1;
        break;
      end
      if (!busy) break;
      if (bus.imem_req) begin
        if (req_cycles == 0) first_addr = bus.imem_addr;
        else if (bus.imem_addr !== first_addr) addr_stable = 1'b0;
        req_cycles++;
        mem_rdata = word;
        mem_ack   = (req_cycles == delay + 1);
      end else begin
        mem_ack = 1'b0;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc_source   = PCS_ALUREG;
    alu_reg     = v;
    branch_type = BR_NONE;
    pc_write    = 1'b1;
    @(negedge clk);
    pc_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rq, lat;
    bit          dn, st;
    logic [31:0] fa;

    bv[0]  = '{BR_EQ,   32'd7,         32'd7,         1'b1};
    bv[1]  = '{BR_EQ,   32'd7,         32'd8,         1'b0};
    bv[2]  = '{BR_NE,   32'd7,         32'd8,         1'b1};
    bv[3]  = '{BR_NE,   32'd7,         32'd7,         1'b0};
    bv[4]  = '{BR_LT,   32'hFFFF_FFFB, 32'd3,         1'b1};
    bv[5]  = '{BR_LT,   32'd3,         32'hFFFF_FFFB, 1'b0};
    bv[6]  = '{BR_LT,   32'd3,         32'd3,         1'b0};
    bv[7]  = '{BR_GT,   32'd3,         32'hFFFF_FFFB, 1'b1};
    bv[8]  = '{BR_GT,   32'hFFFF_FFFB, 32'd3,         1'b0};
    bv[9]  = '{BR_EQZ,  32'd0,         32'd9,         1'b1};
    bv[10] = '{BR_EQZ,  32'd1,         32'd0,         1'b0};
    bv[11] = '{BR_NONE, 32'd5,         32'd5,         1'b0};
    bv[12] = '{3'b110,  32'd5,         32'd5,         1'b0};
    bv[13] = '{3'b111,  32'd0,         32'd0,         1'b0};

    pv[0] = '{32'h0000_FFFE, 32'h10,  PCS_ALU,    32'h1234, 32'h0,   BR_EQ,   32'd7, 32'd7,
              1'b1, 32'h0E};
    pv[1] = '{32'hFC00_0004, 32'h20,  PCS_JUMP,   32'h0,    32'h0,   BR_NONE, 32'd0, 32'd0,
              1'b0, 32'h24};
    pv[2] = '{32'h0000_0000, 32'h20,  PCS_ALUREG, 32'h0,    32'h55,  BR_NONE, 32'd0, 32'd0,
              1'b0, 32'h55};
    pv[3] = '{32'h0000_0000, 32'h20,  PCS_ALU,    32'h1234_5678, 32'h0, BR_NONE, 32'd0, 32'd0,
              1'b0, 32'h1234_5678};
    pv[4] = '{32'h0000_0008, 32'h40,  PCS_ALU,    32'h100,  32'h0,   BR_NE,   32'd3, 32'd3,
              1'b0, 32'h100};
    pv[5] = '{32'h03FF_FFF0, 32'h20,  PCS_JUMP,   32'h0,    32'h0,   BR_NONE, 32'd0, 32'd0,
              1'b0, 32'h10};
    pv[6] = '{32'h0000_0008, 32'h100, PCS_ALUREG, 32'h0,    32'h777, BR_LT,
              32'hFFFF_FFFF, 32'd1, 1'b1, 32'h108};
    pv[7] = '{32'h0000_0008, 32'h100, PCS_ALUREG, 32'h0,    32'h30,  BR_GT,
              32'hFFFF_FFFF, 32'd1, 1'b0, 32'h30};

    reset = 1'b1; fetch_start = 1'b0; pc_write = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    alu_wire = '0; alu_reg = '0; reg_a = '0; reg_b = '0; pc_source = PCS_ALU;
    branch_type = BR_NONE;
    repeat (2) @(negedge clk);
    check("reset_pc", pc, 32'h0);
    check("reset_ir", ir, 32'h0);
    check("reset_req", {31'b0, bus.imem_req}, 32'h0);
    check("reset_done", {31'b0, fetch_done}, 32'h0);
    check("reset_err", {31'b0, fetch_err}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;

    // Zero-wait fetch.
    run_fetch(32'h2021_0005, 0, rq, lat, dn, st, fa);
    check("zw_done_seen", {31'b0, dn}, 32'h1);
    check("zw_latency", lat, 32'd2);
    check("zw_ir", ir, 32'h2021_0005);
    check("zw_addr", fa, 32'h0);
    @(negedge clk);
    check("zw_idle", {31'b0, busy}, 32'h0);

    // Three wait states.
    run_fetch(32'h1111_2222, 3, rq, lat, dn, st, fa);
    check("ws_req_cycles", rq, 32'd4);
    check("ws_addr_stable", {31'b0, st}, 32'h1);
    check("ws_latency", lat, 32'd5);
    check("ws_ir", ir, 32'h1111_2222);
    @(negedge clk);

    // No ack: timeout.
    run_fetch(32'h0BAD_0BAD, 1000, rq, lat, dn, st, fa);
    check("to_req_cycles", rq, Timeout);
    check("to_no_done", {31'b0, dn}, 32'h0);
    check("to_err", {31'b0, fetch_err}, 32'h1);
    check("to_ir_kept", ir, 32'h1111_2222);
    check("to_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    check("to_err_sticky", {31'b0, fetch_err}, 32'h1);

    // Branch condition table.
    for (int i = 0; i < 14; i++) begin
      branch_type = bv[i].bt; reg_a = bv[i].a; reg_b = bv[i].b;
      #1;
      check($sformatf("br_vec%0d", i), {31'b0, branch_taken}, {31'b0, bv[i].exp});
    end
    branch_type = BR_NONE;

    // Next-PC table.
    for (int i = 0; i < 8; i++) begin
      run_fetch(pv[i].ir_word, 0, rq, lat, dn, st, fa);
      @(negedge clk);
      set_pc(pv[i].start_pc);
      pc_source = pv[i].src; alu_wire = pv[i].alu_w; alu_reg = pv[i].alu_r;
      branch_type = pv[i].bt; reg_a = pv[i].a; reg_b = pv[i].b;
      #1;
      check($sformatf("pc_vec%0d_taken", i), {31'b0, branch_taken}, {31'b0, pv[i].exp_taken});
      pc_write = 1'b1;
      @(negedge clk);
      pc_write = 1'b0;
      branch_type = BR_NONE;
      check($sformatf("pc_vec%0d_pc", i), pc, pv[i].exp_pc);
    end

    // pc_write dropped during FETCH, accepted in DONE.
    set_pc(32'h40);
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    pc_source = PCS_ALUREG; alu_reg = 32'h99; pc_write = 1'b1;
    @(negedge clk);
    pc_write = 1'b0;
    check("fw_pc_unchanged", pc, 32'h40);
    check("fw_addr", bus.imem_addr, 32'h40);
    check("fw_busy", {31'b0, busy}, 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
    @(negedge clk);
    mem_ack = 1'b0;
    check("fw_done", {31'b0, fetch_done}, 32'h1);
    pc_write = 1'b1;
    @(negedge clk);
    pc_write = 1'b0;
    check("fw_done_write", pc, 32'h99);
    check("fw_back_idle", {31'b0, busy}, 32'h0);

    // Reset mid-fetch; a late ack must be ignored.
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    check("rf_req_before", {31'b0, bus.imem_req}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rf_req_after", {31'b0, bus.imem_req}, 32'h0);
    check("rf_busy", {31'b0, busy}, 32'h0);
    check("rf_err_cleared", {31'b0, fetch_err}, 32'h0);
    check("rf_pc", pc, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    mem_ack = 1'b0;
    check("rf_late_ack_ir", ir, 32'h0);
    check("rf_no_done", {31'b0, fetch_done}, 32'h0);

    // Wrap: 8-bit PC at 0xFF plus branch offset +1.
    run_fetch(32'h0000_0001, 0, rq, lat, dn, st, fa);
    @(negedge clk);
    set_pc(32'hFF);
    pc_source = PCS_BRANCH; branch_type = BR_NONE; pc_write = 1'b1;
    @(negedge clk);
    pc_write = 1'b0;
    check("wrap_pc8", {24'b0, pc8}, 32'h00);
    check("wrap_pc32", pc, 32'h100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
